// File: rtl/button_step_pulser_if.sv
// Push-button side of button_step_pulser: raw level in, debounced level,
// step strobe and strobe count out.
interface button_step_pulser_if;
  logic       btn_raw;
  logic       btn_level;
  logic       step_pulse;
  logic [7:0] press_count;

  modport master (
    output btn_raw,
    input  btn_level,
    input  step_pulse,
    input  press_count
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output step_pulse,
    output press_count
  );
endinterface

// File: rtl/button_step_pulser.sv
// Synchronises and debounces a push-button and turns each press into a one-cycle step strobe.
// Define BUTTON_STEP_PULSER_AUTOREPEAT_EN to add hold-to-repeat strobes.
module button_step_pulser #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                 clk_50MHz,
  input logic                 clear,
  button_step_pulser_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W)) begin : g_bad_debounce
    $error("button_step_pulser: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("button_step_pulser: REPEAT_DELAY must be >= 2 and REPEAT_PERIOD >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] db_cnt;
  logic             level;
  state_t           state;
  logic             pulse;
  logic [7:0]       count;

`ifdef BUTTON_STEP_PULSER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  // rep_cnt holds cycles since the last strobe; rep_first selects the initial delay
  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic             rep_due;

  assign rep_due = rep_first ? (rep_cnt == REP_W'(REPEAT_DELAY - 1))
                             : (rep_cnt == REP_W'(REPEAT_PERIOD - 1));
`endif

  // Stage p0/p1: two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_p1 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      level  <= ~level;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press FSM: strobe registered on entry to FIRE, HOLD waits for release
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      pulse <= 1'b0;
`ifdef BUTTON_STEP_PULSER_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (level) begin
            state <= FIRE;
            pulse <= 1'b1;
          end
        end
        FIRE: begin
          state <= HOLD;
`ifdef BUTTON_STEP_PULSER_AUTOREPEAT_EN
          rep_cnt   <= REP_W'(1);
          rep_first <= 1'b1;
`endif
        end
        HOLD: begin
          if (!level) begin
            state <= IDLE;
`ifdef BUTTON_STEP_PULSER_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end
`ifdef BUTTON_STEP_PULSER_AUTOREPEAT_EN
          else if (rep_due) begin
            pulse     <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe counter, wraps naturally at 8 bits
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      count <= 8'd0;
    end else if (pulse) begin
      count <= count + 8'd1;
    end
  end

  assign bus.btn_level   = level;
  assign bus.step_pulse  = pulse;
  assign bus.press_count = count;

endmodule

// File: tb/tb_button_step_pulser.sv
// Directed bench for button_step_pulser with DEBOUNCE_CYCLES=4, CNT_W=3,
// REPEAT_DELAY=10, REPEAT_PERIOD=3; follows BUTTON_STEP_PULSER_AUTOREPEAT_EN.
module tb_button_step_pulser;

  logic clk_50MHz = 1'b0;
  logic clear     = 1'b0;
  int   total     = 0;
  int   bad       = 0;
  int   exp_count = 0;

  always #5 clk_50MHz = ~clk_50MHz;

  button_step_pulser_if bus ();

  button_step_pulser #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .clear    (clear),
    .bus      (bus.slave)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50MHz);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    #2;
    clear = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    bus.btn_raw = 1'b0;
    #1 clear = 1'b1;
    #1;
    total++;
    if (bus.btn_level !== 1'b0) begin bad++; $display("FAIL reset_level: got %b want 0", bus.btn_level); end
    total++;
    if (bus.step_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", bus.step_pulse); end
    total++;
    if (bus.press_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.press_count); end
    tick(3);
    clear = 1'b0;
    tick(8);
    total++;
    if ({bus.btn_level, bus.step_pulse, bus.press_count} !== 10'd0) begin
      bad++;
      $display("FAIL reset_idle: got level=%b pulse=%b count=%0d want all 0",
               bus.btn_level, bus.step_pulse, bus.press_count);
    end
    exp_count = 0;
  endtask

  task automatic test_single_press();
    bus.btn_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      total++;
      if (bus.btn_level !== (k >= 6)) begin bad++; $display("FAIL press_level edge %0d: got %b want %b", k, bus.btn_level, (k >= 6)); end
      total++;
      if (bus.step_pulse !== (k == 7)) begin bad++; $display("FAIL press_pulse edge %0d: got %b want %b", k, bus.step_pulse, (k == 7)); end
      total++;
      if (bus.press_count !== ((k >= 8) ? 8'd1 : 8'd0)) begin
        bad++;
        $display("FAIL press_count edge %0d: got %0d want %0d", k, bus.press_count, (k >= 8) ? 1 : 0);
      end
    end
    exp_count = 1;
    bus.btn_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      total++;
      if (bus.btn_level !== (k < 6)) begin bad++; $display("FAIL release_level edge %0d: got %b want %b", k, bus.btn_level, (k < 6)); end
      total++;
      if (bus.step_pulse !== 1'b0) begin bad++; $display("FAIL release_pulse edge %0d: got %b want 0", k, bus.step_pulse); end
    end
    total++;
    if (bus.press_count !== 8'(exp_count)) begin bad++; $display("FAIL release_count: got %0d want %0d", bus.press_count, exp_count); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int lvl_hi = 0;
    for (int i = 0; i < 15; i++) begin
      bus.btn_raw = (i < 3);
      tick(1);
      if (bus.step_pulse === 1'b1) pulses++;
      if (bus.btn_level !== 1'b0) lvl_hi++;
    end
    total++;
    if (lvl_hi != 0) begin bad++; $display("FAIL glitch_level: got %0d cycles high want 0", lvl_hi); end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL glitch_pulse: got %0d pulses want 0", pulses); end
    total++;
    if (bus.press_count !== 8'(exp_count)) begin bad++; $display("FAIL glitch_count: got %0d want %0d", bus.press_count, exp_count); end
  endtask

  task automatic test_bounce();
    int press_pulses = 0;
    int rel_pulses   = 0;
    for (int i = 0; i < 26; i++) begin
      bus.btn_raw = (i == 0) || (i == 2) || (i >= 4 && i <= 11) || (i == 13);
      tick(1);
      if (bus.step_pulse === 1'b1) begin
        if (i < 14) press_pulses++;
        else        rel_pulses++;
      end
      if (i == 11) begin
        total++;
        if (bus.btn_level !== 1'b1) begin bad++; $display("FAIL bounce_level_pressed: got %b want 1", bus.btn_level); end
      end
    end
    exp_count++;
    total++;
    if (press_pulses != 1) begin bad++; $display("FAIL bounce_press_pulses: got %0d want 1", press_pulses); end
    total++;
    if (rel_pulses != 0) begin bad++; $display("FAIL bounce_release_pulses: got %0d want 0", rel_pulses); end
    total++;
    if (bus.btn_level !== 1'b0) begin bad++; $display("FAIL bounce_level_released: got %b want 0", bus.btn_level); end
    total++;
    if (bus.press_count !== 8'(exp_count)) begin bad++; $display("FAIL bounce_count: got %0d want %0d", bus.press_count, exp_count); end
  endtask

  task automatic test_clear_hold();
    bus.btn_raw = 1'b1;
    tick(9);
    total++;
    if (bus.press_count !== 8'(exp_count + 1)) begin bad++; $display("FAIL hold_count: got %0d want %0d", bus.press_count, exp_count + 1); end
    #3 clear = 1'b1;
    #1;
    total++;
    if ({bus.btn_level, bus.step_pulse, bus.press_count} !== 10'd0) begin
      bad++;
      $display("FAIL clear_async: got level=%b pulse=%b count=%0d want all 0",
               bus.btn_level, bus.step_pulse, bus.press_count);
    end
    tick(2);
    total++;
    if ({bus.btn_level, bus.step_pulse, bus.press_count} !== 10'd0) begin
      bad++;
      $display("FAIL clear_held: got level=%b pulse=%b count=%0d want all 0",
               bus.btn_level, bus.step_pulse, bus.press_count);
    end
    clear = 1'b0;
    exp_count = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      total++;
      if (bus.step_pulse !== (k == 7)) begin bad++; $display("FAIL post_clear_pulse edge %0d: got %b want %b", k, bus.step_pulse, (k == 7)); end
      total++;
      if (bus.btn_level !== (k >= 6)) begin bad++; $display("FAIL post_clear_level edge %0d: got %b want %b", k, bus.btn_level, (k >= 6)); end
    end
    exp_count = 1;
    bus.btn_raw = 1'b0;
    tick(12);
    total++;
    if (bus.press_count !== 8'(exp_count)) begin bad++; $display("FAIL post_clear_count: got %0d want %0d", bus.press_count, exp_count); end
  endtask

  task automatic test_autorepeat();
    int  pulses = 0;
    logic want;
    for (int k = 1; k <= 45; k++) begin
      bus.btn_raw = (k <= 30);
      tick(1);
`ifdef BUTTON_STEP_PULSER_AUTOREPEAT_EN
      want = (k == 7) || (k >= 17 && k <= 35 && ((k - 17) % 3) == 0);
`else
      want = (k == 7);
`endif
      if (bus.step_pulse === 1'b1) pulses++;
      total++;
      if (bus.step_pulse !== want) begin bad++; $display("FAIL hold_pulse edge %0d: got %b want %b", k, bus.step_pulse, want); end
    end
`ifdef BUTTON_STEP_PULSER_AUTOREPEAT_EN
    exp_count += 8;
`else
    exp_count += 1;
`endif
    total++;
    if (bus.press_count !== 8'(exp_count)) begin bad++; $display("FAIL hold_count_total: got %0d want %0d (pulses seen %0d)", bus.press_count, exp_count, pulses); end
    total++;
    if (bus.btn_level !== 1'b0) begin bad++; $display("FAIL hold_level_released: got %b want 0", bus.btn_level); end
  endtask

  task automatic test_back_to_back_wrap();
    int pulses;
    pulse_clear();
    for (int p = 0; p < 256; p++) begin
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
        bus.btn_raw = (i < 8);
        tick(1);
        if (bus.step_pulse === 1'b1) pulses++;
      end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL b2b_pulses press %0d: got %0d want 1", p, pulses); end
      if (p == 254) begin
        total++;
        if (bus.press_count !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", bus.press_count); end
      end
    end
    total++;
    if (bus.press_count !== 8'd0) begin bad++; $display("FAIL wrap_0: got %0d want 0", bus.press_count); end
  endtask

  initial begin
    bus.btn_raw = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_bounce();
    test_clear_hold();
    test_autorepeat();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_step_pulser.md
BUTTON_STEP_PULSER -- requirements
Module: button_step_pulser

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable-sample count required to accept a level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 19, debounce counter width, with 2^CNT_W >= DEBOUNCE_CYCLES.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000, hold time before the first auto-repeat pulse (AUTOREPEAT_EN builds only).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5000000, spacing of later auto-repeat pulses (AUTOREPEAT_EN builds only).
REQ-005 SHALL have port clk_50MHz, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port clear, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port btn_raw, input, 1 bit: unsynchronised, bouncing push-button level, 1 = pressed.
REQ-008 SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-009 SHALL have port step_pulse, output, 1 bit: single-cycle step strobe, usable as a processor clock-enable.
REQ-010 SHALL have port press_count, output, 8 bits: count of step_pulse strobes issued.

Function
REQ-011 SHALL pass btn_raw through a two-flop synchronizer before any other logic uses it.
REQ-012 SHALL clear the debounce counter on every cycle in which the synchronized input equals btn_level.
REQ-013 SHALL increment the counter while the synchronized input differs from btn_level, and invert btn_level on the DEBOUNCE_CYCLES-th consecutive differing cycle, clearing the counter on that same edge.
REQ-014 SHALL produce btn_level rise or fall DEBOUNCE_CYCLES+2 edges after btn_raw is first sampled at its new value, given no bounce.
REQ-015 SHALL discard any glitch shorter than DEBOUNCE_CYCLES synchronized cycles: btn_level does not change and no pulse is issued.
REQ-016 SHALL use FSM states IDLE, FIRE and HOLD.
REQ-017 SHALL transition IDLE->FIRE on the first cycle btn_level=1, FIRE->HOLD unconditionally, HOLD->IDLE when btn_level=0, and otherwise remain in the current state.
REQ-018 SHALL register step_pulse high for exactly the one cycle in which the state is FIRE; latency from btn_raw sample to step_pulse is DEBOUNCE_CYCLES+3 edges.
REQ-019 SHALL issue exactly one step_pulse per debounced press, regardless of hold length, when AUTOREPEAT_EN is undefined.
REQ-020 SHALL issue no pulse on release.
REQ-021 SHALL increment press_count on the edge following each step_pulse, wrapping from 255 to 0 without saturation.
REQ-022 SHALL allow back-to-back presses separated by at least DEBOUNCE_CYCLES+1 released cycles, each yielding one pulse.

Reset
REQ-023 SHALL, while clear=1, force both synchronizer flops, btn_level, step_pulse, press_count, all counters and the FSM (IDLE) to 0 immediately, independent of clk_50MHz.
REQ-024 SHALL issue no pulse after clear deasserts until btn_raw has been qualified for DEBOUNCE_CYCLES again, even if btn_raw is held 1 across the deassertion.
REQ-025 SHALL abort any in-progress debounce, HOLD or repeat timing on clear, with no partial pulse.

Configuration
REQ-026 SHALL, with macro BUTTON_STEP_PULSER_AUTOREPEAT_EN defined, add a repeat timer that runs in HOLD and issues an extra one-cycle step_pulse REPEAT_DELAY cycles after the FIRE pulse, then every REPEAT_PERIOD cycles while btn_level=1.
REQ-027 SHALL reset the repeat timer when btn_level falls, and count repeat pulses in press_count.
REQ-028 SHALL, without the macro, omit the repeat timer and REPEAT_* logic entirely, giving single-shot behaviour per REQ-019.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 SHALL cover: clear pulse, btn_raw held 1 -> btn_level=1 at edge 6, step_pulse high at edge 7 only, press_count=1 at edge 8.
REQ-030 SHALL cover: btn_raw glitch high for 3 cycles -> btn_level stays 0, no step_pulse, press_count=0.
REQ-031 SHALL cover: btn_raw bouncing 1,0,1,0 then stable 1 -> exactly one step_pulse; release bouncing -> none.
REQ-032 SHALL cover: 256 clean presses -> press_count wraps to 0.
REQ-033 SHALL cover: clear asserted mid-HOLD with btn_raw=1 -> all outputs 0 at once; after release, a new pulse appears DEBOUNCE_CYCLES+3 edges later.
REQ-034 SHALL cover: macro defined, btn_raw held 30 cycles -> pulses at FIRE, +10, +13, +16 and so on until release; macro undefined -> one pulse only.
